// File: rtl/mpuc_feed.sv
// Feeder/sequencer for the time-multiplexed MPUC constant multipliers: serializes
// complex samples into DS-framed pairs, issues twiddle controls and tracks result latency.
module mpuc_feed #(
   parameter int total_bits = 32,
   parameter int LOG2N      = 4,
   parameter int MUL_LAT    = 4
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic                  ED,
   input  logic                  IN_VLD,
   output logic                  IN_RDY,
   input  logic [total_bits-1:0] IN_RE,
   input  logic [total_bits-1:0] IN_IM,
   output logic                  DS,
   output logic [total_bits-1:0] DR,
   output logic [total_bits-1:0] DI,
   output logic                  MPYJ,
   output logic                  NEG,
   output logic                  MSEL,
   output logic                  RES_VLD,
   output logic [LOG2N-1:0]      RES_IDX,
   output logic                  RES_NEG,
   output logic                  FRAME_END
);

   typedef enum logic {PH_A = 1'b0, PH_B = 1'b1} phase_t;

   localparam logic [LOG2N-1:0] IDX_LAST = '1;

   phase_t           ph_q, ph_d;
   logic             accept;
   logic [LOG2N-1:0] k_q;
   logic [LOG2N-1:0] pair_idx_q;
   logic [2:0]       m;

   logic [MUL_LAT:1] dl_vld;
   logic [MUL_LAT:1] dl_neg;
   logic [LOG2N-1:0] dl_idx [1:MUL_LAT];

   always_comb begin
      ph_d   = ph_q;
      IN_RDY = RSTN & ED & (ph_q == PH_A);
      accept = IN_RDY & IN_VLD;
      if (ED) begin
         case (ph_q)
            PH_A:    if (accept) ph_d = PH_B;
            PH_B:    ph_d = PH_A;
            default: ph_d = PH_A;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) ph_q <= PH_A;
      else       ph_q <= ph_d;
   end

   // zero-extended so narrow frames (LOG2N < 3) still map cleanly
   always_comb m = 3'(k_q);

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         k_q        <= '0;
         pair_idx_q <= '0;
         DS         <= 1'b0;
         DR         <= '0;
         DI         <= '0;
         MSEL       <= 1'b0;
         MPYJ       <= 1'b0;
         NEG        <= 1'b0;
      end else if (ED) begin
         if (accept) begin
            DR         <= IN_RE;
            DI         <= IN_IM;
            DS         <= 1'b1;
            MSEL       <= m[0];
            MPYJ       <= m[1];
            NEG        <= m[2];
            pair_idx_q <= k_q;
            k_q        <= k_q + LOG2N'(1);
         end else begin
            DS <= 1'b0;
         end
      end
   end

   // Fed from the DS stage, so tap MUL_LAT lines up with MUL_LAT cycles after DS=1.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         dl_vld <= '0;
         dl_neg <= '0;
         for (int unsigned i = 1; i <= MUL_LAT; i++) dl_idx[i] <= '0;
      end else if (ED) begin
         dl_vld[1] <= DS;
         dl_neg[1] <= NEG;
         dl_idx[1] <= pair_idx_q;
         for (int unsigned i = 2; i <= MUL_LAT; i++) begin
            dl_vld[i] <= dl_vld[i-1];
            dl_neg[i] <= dl_neg[i-1];
            dl_idx[i] <= dl_idx[i-1];
         end
      end
   end

   always_comb begin
      RES_VLD   = dl_vld[MUL_LAT];
      RES_IDX   = dl_idx[MUL_LAT];
      RES_NEG   = dl_vld[MUL_LAT] & dl_neg[MUL_LAT];
      FRAME_END = dl_vld[MUL_LAT] & (dl_idx[MUL_LAT] == IDX_LAST);
   end

endmodule

// File: doc/mpuc_feed.md
# mpuc_feed

Serializing feeder and sequencer for the time-multiplexed constant-multiplier units (the MPUC family) in the pipelined FFT datapath. It accepts complex samples over a valid/ready handshake and presents each one to the multiplier as a two-cycle DS-framed pair. For every sample it generates the MPYJ, negate and constant-select controls from a running twiddle index. It also tracks the multiplier latency, so downstream logic receives a strobe with the matching index when each rotated result appears on DOR/DOI.

## Interface
- total_bits, 32, sample width (real and imaginary, signed two's complement)
- LOG2N, 4, log2 of frame length N; index counter width
- MUL_LAT, 4, ED-qualified cycles from a DS=1 issue cycle to the first cycle the paired multiplier's DOR/DOI hold that sample's result

Ports:
- CLK  in  1  clock; all state on rising edge
- RSTN  in  1  asynchronous active-low reset
- ED  in  1  pipeline enable; when low, all state holds (including the handshake; IN_RDY forced 0)
- IN_VLD  in  1  input sample valid
- IN_RDY  out  1  feeder accepts a sample this cycle
- IN_RE, IN_IM  in  total_bits  input sample, signed
- DS  out  1  data strobe to multiplier: 1 on the real/first cycle of a pair
- DR, DI  out  total_bits  registered sample to multiplier
- MPYJ  out  1  multiply result by -j
- NEG  out  1  negate result (applied downstream)
- MSEL  out  1  0 = bypass path, 1 = constant-multiplier path
- RES_VLD  out  1  multiplier output valid this cycle
- RES_IDX  out  LOG2N  twiddle index of the result on RES_VLD
- RES_NEG  out  1  NEG flag aligned to RES_VLD
- FRAME_END  out  1  one-cycle pulse with RES_VLD of index N-1

## Operation
- Phase toggle `ph` (0 = A, 1 = B) advances only when ED=1.
- Phase A:
  - IN_RDY = ED & ~ph.
  - On accept (IN_VLD & IN_RDY): DR<=IN_RE, DI<=IN_IM, DS<=1, and the controls are registered from index k; then ph<=1 and k<=k+1, wrapping N-1 -> 0.
- Phase A with IN_VLD=0: DS<=0, DR/DI hold, ph stays 0 (bubble). No index advance.
- Phase B: DS<=0, DR/DI hold, ph<=0. IN_RDY=0 regardless of IN_VLD.
- Control mapping, with m = k[2:0]: MSEL=m[0], MPYJ=m[1], NEG=m[2]. Controls hold until the next accept.
- Result tracking:
  - A shift register of depth MUL_LAT carries {issued, k, NEG}, shifted only when ED=1.
  - "issued" is 1 only on accept cycles.
  - The tap at MUL_LAT drives RES_VLD, RES_IDX and RES_NEG.
  - FRAME_END = RES_VLD & (RES_IDX==N-1).
- The frame index k is independent of RES tracking. Back-to-back frames are seamless.
- Reset (any time, mid-pair included): outputs DS, MPYJ, NEG, MSEL, RES_VLD, RES_NEG, FRAME_END = 0; DR, DI, RES_IDX = 0; IN_RDY = 0 while RSTN=0; ph=0, k=0; delay line cleared. After release, the first accepted sample has k=0.

## Timing
- Throughput: at most one sample per 2 ED cycles. With IN_VLD held high, IN_RDY is high on alternate ED cycles.
- Latency:
  - Accept at edge t gives DS=1 during cycle t+1.
  - RES_VLD is high exactly MUL_LAT ED-qualified cycles after that DS=1 cycle, for one ED cycle.
- ED low for n cycles stretches all latencies by n. No strobe is lost or duplicated.
- Simultaneous events:
  - Wrap at the same edge as an accept: the sample gets index N-1 and the next one gets 0.
  - RES_VLD and a new accept at the same edge are independent.
- The sample width passes unchanged; no arithmetic on data.

## Test plan
- Reset mid-pair: accept a sample, pull RSTN low in phase B → all outputs 0 immediately (async). After release, the next accept carries k=0 and RES_VLD fires only for post-reset samples.
- Full-rate stream: IN_VLD=1 for 16 samples, IN_RE=k, IN_IM=-k, ED=1 → DS pattern 1,0,1,0…; DR=k on each DS=1 cycle; RES_VLD on every other cycle with RES_IDX 0..15; FRAME_END on index 15 only.
- Control mapping: k=5 → MSEL=1, MPYJ=0, NEG=1. k=6 → MSEL=0, MPYJ=1, NEG=1. k=8 → all 0.
- Bubbles: IN_VLD low for 3 cycles between samples 2 and 3 → no index skip; sample 3 has RES_IDX=3; RES_VLD gaps mirror the input gaps.
- ED stall: drop ED for 5 cycles right after an accept → DS, DR, RES pipeline and IN_RDY=0 frozen. RES_VLD for that sample arrives 5 cycles later than unstalled, exactly once.
- Wrap with LOG2N=2: 6 samples → RES_IDX 0,1,2,3,0,1; FRAME_END once.
